lstm_step_sched: RTL and testbench

Timestep scheduler for the LSTM layer datapath. It sequences input-vector (x) and recurrent (h) memory reads for every timestep, then waits for the MAC pipeline to drain and runs the cell-update window. It replaces free-running per-memory address counters with one controller that owns the read addresses, the enables and the phase timing. It sits between the layer-level start/done handshake and the x/h buffer read ports plus the gate accumulators.

---
 rtl/lstm_ctrl_pkg.sv | 18 +
 rtl/lstm_phase_cnt.sv | 28 ++
 rtl/lstm_step_sched.sv | 174 +++++++++++++++++
 tb/tb_lstm_step_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_ctrl_pkg.sv
// Shared LSTM layer control definitions: scheduler states and the
// default layer geometry used by the buffers and address generators.
package lstm_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_X,
      S_H,
      S_DRAIN,
      S_UPD,
      S_DONE
   } state_t;

   localparam int LSTM_X_LEN    = 53;
   localparam int LSTM_H_LEN    = 53;
   localparam int LSTM_TIMESTEP = 7;

endpackage

// File: rtl/lstm_phase_cnt.sv
// Loadable down-counter that only moves when not stalled; tc flags the
// last cycle of a phase.
module lstm_phase_cnt #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/lstm_step_sched.sv
// Timestep scheduler: sequences x/h buffer reads, pipeline drain and
// the cell-update window for every timestep of an LSTM sequence.
module lstm_step_sched
   import lstm_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int X_LEN      = LSTM_X_LEN,
   parameter int H_LEN      = LSTM_H_LEN,
   parameter int TIMESTEP   = LSTM_TIMESTEP,
   parameter int DELAY      = 1,
   parameter int UPD_CYC    = 4,
   parameter int TS_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_stall,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_en_x,
   output logic [ADDR_WIDTH-1:0] o_addr_x,
   output logic                  o_en_h,
   output logic [ADDR_WIDTH-1:0] o_addr_h,
   output logic                  o_acc_clr,
   output logic                  o_upd,
   output logic [TS_WIDTH-1:0]   o_timestep
);

   localparam int AW       = ADDR_WIDTH;
   localparam int CW       = 16;
   localparam int DELAY_M1 = (DELAY == 0) ? 0 : DELAY - 1;
   localparam state_t EXIT_ST  = (DELAY == 0) ? S_UPD : S_DRAIN;
   localparam logic   EXIT_UPD = (DELAY == 0);

   state_t              state;
   logic [AW-1:0]       x_base;
   logic [AW-1:0]       h_base;
   logic [TS_WIDTH-1:0] ts;

   logic          run;
   logic          idx_tc, cnt_tc;
   logic          x_last, h_last, io_exit;
   logic          drain_last, upd_last, seq_last;
   logic          idx_load, idx_dec;
   logic [AW-1:0] idx_val;
   logic          cnt_load, cnt_dec;
   logic [CW-1:0] cnt_val;

   assign run        = ~i_stall;
   assign x_last     = (state == S_X) && run && idx_tc;
   assign h_last     = (state == S_H) && run && idx_tc;
   assign io_exit    = (x_last && ts == '0) || h_last;
   assign drain_last = (state == S_DRAIN) && run && cnt_tc;
   assign upd_last   = (state == S_UPD) && run && cnt_tc;
   assign seq_last   = (ts == TS_WIDTH'(TIMESTEP - 1));

   assign idx_load = (state == S_IDLE && i_start)
                   || (x_last && ts != '0)
                   || (upd_last && !seq_last);
   assign idx_val  = (state == S_X) ? AW'(H_LEN - 1) : AW'(X_LEN - 1);
   assign idx_dec  = ((state == S_X) || (state == S_H)) && run;

   // The X/H exit loads the drain length, or the update length when
   // there is no drain phase.
   assign cnt_load = io_exit || drain_last;
   assign cnt_val  = (io_exit && DELAY != 0) ? CW'(DELAY_M1)
                                             : CW'(UPD_CYC - 1);
   assign cnt_dec  = ((state == S_DRAIN) || (state == S_UPD)) && run;

   lstm_phase_cnt #(.W(AW)) u_idx (
      .clk      (clk),
      .rst      (rst),
      .load     (idx_load),
      .load_val (idx_val),
      .dec      (idx_dec),
      .tc       (idx_tc)
   );

   lstm_phase_cnt #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .tc       (cnt_tc)
   );

   assign o_en_x     = (state == S_X) && run;
   assign o_en_h     = (state == S_H) && run;
   assign o_timestep = ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ts        <= '0;
         x_base    <= '0;
         h_base    <= '0;
         o_addr_x  <= '0;
         o_addr_h  <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_acc_clr <= 1'b0;
         o_upd     <= 1'b0;
      end else begin
         o_acc_clr <= 1'b0;
         o_done    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  state     <= S_X;
                  ts        <= '0;
                  x_base    <= '0;
                  h_base    <= '0;
                  o_addr_x  <= '0;
                  o_acc_clr <= 1'b1;
                  o_busy    <= 1'b1;
               end
            end
            S_X: begin
               if (x_last) begin
                  if (ts == '0) begin
                     state <= EXIT_ST;
                     o_upd <= EXIT_UPD;
                  end else begin
                     state    <= S_H;
                     o_addr_h <= h_base;
                  end
               end else if (run) begin
                  o_addr_x <= o_addr_x + 1'b1;
               end
            end
            S_H: begin
               if (h_last) begin
                  state <= EXIT_ST;
                  o_upd <= EXIT_UPD;
               end else if (run) begin
                  o_addr_h <= o_addr_h + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_last) begin
                  state <= S_UPD;
                  o_upd <= 1'b1;
               end
            end
            S_UPD: begin
               if (upd_last) begin
                  o_upd <= 1'b0;
                  if (seq_last) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state     <= S_X;
                     ts        <= ts + 1'b1;
                     h_base    <= (ts == '0) ? '0 : h_base + AW'(H_LEN);
                     x_base    <= x_base + AW'(X_LEN);
                     o_addr_x  <= x_base + AW'(X_LEN);
                     o_acc_clr <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               o_busy   <= 1'b0;
               ts       <= '0;
               o_addr_x <= '0;
               o_addr_h <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lstm_step_sched.sv
// Bench for lstm_step_sched: per-cycle trace against a phase-list model,
// plus directed stall, restart, reset-abort and small-config runs.
module tb_lstm_step_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic a_start, a_stall, a_busy, a_done, a_en_x, a_en_h;
   logic a_clr, a_upd;
   logic [11:0] a_ax, a_ah;
   logic [2:0]  a_ts;
   logic b_start, b_stall, b_busy, b_done, b_en_x, b_en_h;
   logic b_clr, b_upd;
   logic [11:0] b_ax, b_ah;
   logic [2:0]  b_ts;

   lstm_step_sched #(
      .ADDR_WIDTH(12), .X_LEN(53), .H_LEN(53), .TIMESTEP(7),
      .DELAY(1), .UPD_CYC(4), .TS_WIDTH(3)
   ) u_a (
      .clk(clk), .rst(rst), .i_start(a_start), .i_stall(a_stall),
      .o_busy(a_busy), .o_done(a_done), .o_en_x(a_en_x),
      .o_addr_x(a_ax), .o_en_h(a_en_h), .o_addr_h(a_ah),
      .o_acc_clr(a_clr), .o_upd(a_upd), .o_timestep(a_ts)
   );

   lstm_step_sched #(
      .ADDR_WIDTH(12), .X_LEN(4), .H_LEN(4), .TIMESTEP(2),
      .DELAY(0), .UPD_CYC(1), .TS_WIDTH(3)
   ) u_b (
      .clk(clk), .rst(rst), .i_start(b_start), .i_stall(b_stall),
      .o_busy(b_busy), .o_done(b_done), .o_en_x(b_en_x),
      .o_addr_x(b_ax), .o_en_h(b_en_h), .o_addr_h(b_ah),
      .o_acc_clr(b_clr), .o_upd(b_upd), .o_timestep(b_ts)
   );

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        en_x;
      logic [11:0] ax;
      logic        en_h;
      logic [11:0] ah;
      logic        clr;
      logic        upd;
      logic [2:0]  ts;
   } obs_t;

   obs_t exp_q[$];
   bit   fix_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic obs_t mk(bit ex, bit eh, bit clr, bit upd,
                               bit dn, int ax, int ah, int t);
      obs_t r;
      r.busy = 1'b1;
      r.done = dn;
      r.en_x = ex;
      r.ax   = 12'(ax);
      r.en_h = eh;
      r.ah   = 12'(ah);
      r.clr  = clr;
      r.upd  = upd;
      r.ts   = 3'(t);
      return r;
   endfunction

   // Expected unstalled trace: one entry per cycle, built phase by phase.
   task automatic build(int xl, int hl, int tsn, int dly, int upc);
      int ax = 0;
      int ah = 0;
      exp_q.delete();
      fix_q.delete();
      for (int t = 0; t < tsn; t++) begin
         for (int i = 0; i < xl; i++) begin
            ax = t * xl + i;
            exp_q.push_back(mk(1, 0, i == 0, 0, 0, ax, ah, t));
            fix_q.push_back(0);
         end
         if (t > 0) begin
            for (int i = 0; i < hl; i++) begin
               ah = (t - 1) * hl + i;
               exp_q.push_back(mk(0, 1, 0, 0, 0, ax, ah, t));
               fix_q.push_back(0);
            end
         end
         for (int d = 0; d < dly; d++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, ax, ah, t));
            fix_q.push_back(0);
         end
         for (int u = 0; u < upc; u++) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, ax, ah, t));
            fix_q.push_back(0);
         end
      end
      exp_q.push_back(mk(0, 0, 0, 0, 1, ax, ah, tsn - 1));
      fix_q.push_back(1);
   endtask

   function automatic obs_t get(bit sel);
      if (sel)
         return obs_t'({b_busy, b_done, b_en_x, b_ax, b_en_h, b_ah,
                        b_clr, b_upd, b_ts});
      return obs_t'({a_busy, a_done, a_en_x, a_ax, a_en_h, a_ah,
                     a_clr, a_upd, a_ts});
   endfunction

   task automatic set_in(bit sel, bit st, bit sl);
      if (sel) begin
         b_start = st;
         b_stall = sl;
      end else begin
         a_start = st;
         a_stall = sl;
      end
   endtask

   // mode: 0 plain, 1 directed H stall, 2 random stall,
   //       3 extra start while busy, 4 reset abort in ts3 X
   task automatic run(bit sel, int mode, output int done_cyc,
                      output int nx, output int nh, output int nclr,
                      output int nstall);
      int   p = 0;
      bit   first = 1;
      int   sleft = 5;
      int   cyc;
      bit   stall;
      bit   aborted = 0;
      obs_t e, o;
      done_cyc = 0;
      nx = 0;
      nh = 0;
      nclr = 0;
      nstall = 0;
      @(negedge clk);
      set_in(sel, 1, 0);
      @(posedge clk);
      #1;
      set_in(sel, 0, 0);
      cyc = 1;
      while (p < exp_q.size() && cyc < 3000) begin
         e = exp_q[p];
         stall = 0;
         if (mode == 1 && e.en_h && e.ts == 3'd2 && e.ah == 12'd73
             && sleft > 0) begin
            stall = 1;
            sleft--;
         end
         if (mode == 2)
            stall = ($urandom_range(0, 3) == 0);
         set_in(sel, mode == 3 && cyc == 100, stall);
         @(negedge clk);
         if (stall && !fix_q[p]) begin
            e.en_x = 0;
            e.en_h = 0;
            nstall++;
         end
         if (!first)
            e.clr = 0;
         o = get(sel);
         chk($sformatf("trace_cyc%0d", cyc), 64'(o), 64'(e));
         if (mode == 1 && stall) begin
            chk("stall_addr_h", 64'(o.ah), 64'd73);
            chk("stall_en_h", 64'(o.en_h), 64'd0);
         end
         nx += int'(o.en_x);
         nh += int'(o.en_h);
         nclr += int'(o.clr);
         if (o.done)
            done_cyc = cyc;
         if (mode == 4 && e.ts == 3'd3 && e.en_x && e.ax == 12'd169) begin
            #1 rst = 1'b1;
            #1 chk("rst_async_zero", 64'(get(sel)), 64'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            aborted = 1;
            break;
         end
         if (!stall || fix_q[p]) begin
            p++;
            first = 1;
         end else begin
            first = 0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!aborted) begin
         chk("cycle_bound", 64'(p), 64'(exp_q.size()));
         set_in(sel, 0, 0);
         @(negedge clk);
         chk("idle_after_done", 64'(get(sel)), 64'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, nx, nh, nc, ns;
      rst = 1'b1;
      set_in(0, 0, 0);
      set_in(1, 0, 0);
      #12;
      chk("reset_a", 64'(get(0)), 64'd0);
      chk("reset_b", 64'(get(1)), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      build(53, 53, 7, 1, 4);
      run(0, 0, dc, nx, nh, nc, ns);
      chk("plain_done_cyc", 64'(dc), 64'd725);
      chk("plain_en_x_cnt", 64'(nx), 64'd371);
      chk("plain_en_h_cnt", 64'(nh), 64'd318);
      chk("plain_clr_cnt", 64'(nc), 64'd7);

      run(0, 1, dc, nx, nh, nc, ns);
      chk("hstall_done_cyc", 64'(dc), 64'd730);
      chk("hstall_en_h_cnt", 64'(nh), 64'd318);
      chk("hstall_clr_cnt", 64'(nc), 64'd7);

      run(0, 3, dc, nx, nh, nc, ns);
      chk("busy_start_done_cyc", 64'(dc), 64'd725);

      run(0, 2, dc, nx, nh, nc, ns);
      chk("rand_done_cyc", 64'(dc), 64'(725 + ns));
      chk("rand_en_x_cnt", 64'(nx), 64'd371);
      chk("rand_clr_cnt", 64'(nc), 64'd7);

      run(0, 4, dc, nx, nh, nc, ns);
      run(0, 0, dc, nx, nh, nc, ns);
      chk("restart_done_cyc", 64'(dc), 64'd725);

      build(4, 4, 2, 0, 1);
      run(1, 0, dc, nx, nh, nc, ns);
      chk("small_done_cyc", 64'(dc), 64'd15);
      chk("small_en_x_cnt", 64'(nx), 64'd8);
      chk("small_en_h_cnt", 64'(nh), 64'd4);
      run(1, 2, dc, nx, nh, nc, ns);
      chk("small_rand_done", 64'(dc), 64'(15 + ns));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
